// File: rtl/jpeg_cone_arbiter.sv
// Round-robin arbiter sharing one jpeg n_5 cone evaluator among NUM_REQ requesters.
// Define JPEG_CONE_ARB_OUTREG_EN to add a registered cone stage (S2) between S1 and R.
module jpeg_cone_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [5*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_y,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic                 busy
);

  localparam int unsigned DATA_W = 5;
  localparam int unsigned IDX_W  = ID_W + 1;

  function automatic logic cone(input logic [DATA_W-1:0] n);
    return ~((n[0] & n[2] & n[3]) | (n[4] & ~n[1]) | ~n[2]);
  endfunction

  logic [ID_W-1:0]   ptr;
  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic [DATA_W-1:0] s1_data;

  logic              r_open;
  logic              s1_open;
  logic              s1_valid_nxt;
  logic              rsp_valid_nxt;

  logic [DATA_W-1:0] ops [NUM_REQ];
  logic [IDX_W-1:0]  idx;
  logic              found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   ptr_nxt;
  logic              hs;

  assign r_open = ~rsp_valid | rsp_ready;

`ifdef JPEG_CONE_ARB_OUTREG_EN
  logic            s2_valid;
  logic [ID_W-1:0] s2_id;
  logic            s2_y;
  logic            s2_open;
  logic            s2_valid_nxt;

  assign s2_open = ~s2_valid | r_open;
  assign s1_open = ~s1_valid | s2_open;
`else
  assign s1_open = ~s1_valid | r_open;
`endif

  // Circular search for the first valid requester at or after ptr.
  always_comb begin
    idx      = '0;
    found    = 1'b0;
    grant_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      ops[k] = req_data[k*DATA_W +: DATA_W];
      idx    = IDX_W'(ptr) + IDX_W'(k);
      if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
      if (!found && req_valid[ID_W'(idx)]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  // Grant is only offered when S1 can load and the block is out of reset.
  always_comb begin
    req_ready = '0;
    hs        = found & s1_open & ~rst;
    if (hs) req_ready[grant_id] = 1'b1;
    ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  // Next-state valid bits, used for the registered busy flag.
  always_comb begin
    s1_valid_nxt = s1_open ? hs : s1_valid;
`ifdef JPEG_CONE_ARB_OUTREG_EN
    s2_valid_nxt  = s2_open ? s1_valid : s2_valid;
    rsp_valid_nxt = r_open ? s2_valid : rsp_valid;
`else
    rsp_valid_nxt = r_open ? s1_valid : rsp_valid;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      issue_cnt <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_data   <= '0;
      busy      <= 1'b0;
    end else begin
      if (hs) begin
        ptr       <= ptr_nxt;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (s1_open) begin
        s1_valid <= hs;
        if (hs) begin
          s1_id   <= grant_id;
          s1_data <= ops[grant_id];
        end
      end
`ifdef JPEG_CONE_ARB_OUTREG_EN
      busy <= s1_valid_nxt | s2_valid_nxt | rsp_valid_nxt;
`else
      busy <= s1_valid_nxt | rsp_valid_nxt;
`endif
    end
  end

`ifdef JPEG_CONE_ARB_OUTREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_y     <= 1'b0;
    end else if (s2_open) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id <= s1_id;
        s2_y  <= cone(s1_data);
      end
    end
  end

  // Response register holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
    end else if (r_open) begin
      rsp_valid <= s2_valid;
      if (s2_valid) begin
        rsp_id <= s2_id;
        rsp_y  <= s2_y;
      end
    end
  end
`else
  // Response register holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= 1'b0;
    end else if (r_open) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id <= s1_id;
        rsp_y  <= cone(s1_data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_cone_arbiter.sv
// Randomized self-checking bench for jpeg_cone_arbiter against an in-flight queue model.
// Honors JPEG_CONE_ARB_OUTREG_EN for latency and pipeline depth.
module tb_jpeg_cone_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;
`ifdef JPEG_CONE_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [5*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_y;
  logic [CNT_W-1:0]     issue_cnt;
  logic                 busy;

  jpeg_cone_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .issue_cnt(issue_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int y; int t;} item_t;
  item_t q[$];
  int obs_g[$];
  int obs_id[$];
  int obs_y[$];
  int mptr = 0;
  int mcnt = 0;
  int cyc  = 0;
  int n_checks = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cone result: n_2 must be set, and neither (n_0,n_3) nor (n_4 without n_1) may both hold.
  function automatic int cone_ref(input logic [4:0] n);
    if (!n[2]) return 0;
    if (n[0] && n[3]) return 0;
    if (n[4] && !n[1]) return 0;
    return 1;
  endfunction

  function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [4:0] val);
    req_data[5*i +: 5] = val;
  endtask

  // One clock: check outputs at negedge, then advance the model across the posedge.
  task automatic step();
    int g;
    int y;
    logic [NUM_REQ-1:0] exp_rdy;
    bit rv;
    @(negedge clk);
    g = (q.size() < DEPTH || rsp_ready) ? exp_grant(req_valid, mptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rv = (q.size() > 0) && ((cyc - q[0].t) >= LAT);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (rv) begin
      check("rsp_id", 32'(rsp_id), 32'(q[0].id));
      check("rsp_y", 32'(rsp_y), 32'(q[0].y));
    end
    check("busy", 32'(busy), 32'(q.size() > 0));
    check("issue_cnt", 32'(issue_cnt), 32'(mcnt));
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i] && req_valid[i]) obs_g.push_back(i);
    if (rsp_valid && rsp_ready) begin
      obs_id.push_back(int'(rsp_id));
      obs_y.push_back(int'(rsp_y));
    end
    y = (g >= 0) ? cone_ref(req_data[5*g +: 5]) : 0;
    @(posedge clk);
    cyc++;
    if (rv && rsp_ready) void'(q.pop_front());
    if (g >= 0) begin
      q.push_back('{g, y, cyc});
      mptr = (g + 1) % NUM_REQ;
      mcnt = (mcnt + 1) % (1 << CNT_W);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_y", 32'(rsp_y), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    q.delete();
    obs_g.delete();
    obs_id.delete();
    obs_y.delete();
    mptr = 0;
    mcnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 0, 1};

    // Single request from requester 2
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 5'h16);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (3) step();
    check("single_grant", 32'(obs_g.size() > 0 ? obs_g[0] : -1), 32'd2);
    check("single_y", 32'(obs_y.size() > 0 ? obs_y[0] : -1), 32'd1);
    check("single_cnt", 32'(issue_cnt), 32'd1);

    // Cone values on requester 0
    do_reset();
    set_req(0, 5'h0D); req_valid = 4'b0001; step();
    set_req(0, 5'h00); step();
    set_req(0, 5'h16); step();
    req_valid = '0;
    repeat (3) step();
    check("cone_n", 32'(obs_y.size()), 32'd3);
    if (obs_y.size() == 3) begin
      check("cone_0d", 32'(obs_y[0]), 32'd0);
      check("cone_00", 32'(obs_y[1]), 32'd0);
      check("cone_16", 32'(obs_y[2]), 32'd1);
    end

    // Round-robin fairness
    do_reset();
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'($urandom));
    repeat (6) step();
    req_valid = '0;
    repeat (3) step();
    check("rr_n", 32'(obs_g.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_g.size()) check("rr_grant", 32'(obs_g[i]), 32'(exp_seq[i]));
      if (i < obs_id.size()) check("rr_rsp_id", 32'(obs_id[i]), 32'(exp_seq[i]));
    end

    // Backpressure: pipeline fills, then drains in order
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (6) step();
    check("bp_handshakes", 32'(obs_g.size()), 32'(DEPTH));
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    check("bp_drained", 32'(obs_id.size()), 32'(DEPTH));

    // Counter wrap with a 4-bit counter
    do_reset();
    req_valid = '1;
    repeat (17) step();
    req_valid = '0;
    check("cnt_wrap", 32'(issue_cnt), 32'd1);
    repeat (3) step();

    // Reset while two requests are in flight
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (2) step();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0110;
    step();
    req_valid = '0;
    check("post_rst_grant", 32'(obs_g.size() > 0 ? obs_g[0] : -1), 32'd1);
    repeat (3) step();

    // Randomized traffic with withdrawals and backpressure
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      req_valid = NUM_REQ'($urandom);
      req_data  = (5*NUM_REQ)'($urandom);
      rsp_ready = (n % 200 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
